sram_1p_masked_array: RTL

- Parametrised single-port (one shared read/write port) masked SRAM array model.
- Next generation of the fixed 2x28 array models used by the cache/predictor data arrays.
- Generalised in depth, width, mask granularity and read latency.
- Adds three behaviours the fixed models lack:
  - hardware zero-initialisation sequence after reset;
  - an explicit read-valid output;
  - a guaranteed read-data hold between reads.

---
 rtl/sram_1p_masked_array.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/sram_1p_masked_array.sv
// Single-port masked SRAM array model with hardware zero-initialisation.
//
// After reset the array walks every entry writing zero, then asserts init_done and
// opens the port. One shared port serves either a masked write or a read per cycle.
// Read results appear READ_LAT cycles after the request edge together with a one-cycle
// RW0_rvalid pulse, and RW0_rdata holds the last result until the next one lands.
//
// Ports:
//   RW0_clk    - clock
//   reset      - asynchronous active-high reset (array contents are not cleared by it)
//   RW0_addr   - entry address
//   RW0_en     - port enable (ignored until init_done)
//   RW0_wmode  - 1 = write, 0 = read
//   RW0_wmask  - per-lane write enable, lane i = bits [i*MASK_GRAN +: MASK_GRAN]
//   RW0_wdata  - write data
//   RW0_rdata  - read data, held between read results
//   RW0_rvalid - one-cycle pulse when RW0_rdata carries a new read result
//   init_done  - high once zero-initialisation has finished
module sram_1p_masked_array #(
   parameter int unsigned DEPTH     = 2,
   parameter int unsigned WIDTH     = 28,
   parameter int unsigned MASK_GRAN = 7,
   parameter int unsigned READ_LAT  = 1,
   parameter int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   parameter int unsigned MW        = WIDTH / MASK_GRAN
) (
   input  logic             RW0_clk,
   input  logic             reset,
   input  logic [AW-1:0]    RW0_addr,
   input  logic             RW0_en,
   input  logic             RW0_wmode,
   input  logic [MW-1:0]    RW0_wmask,
   input  logic [WIDTH-1:0] RW0_wdata,
   output logic [WIDTH-1:0] RW0_rdata,
   output logic             RW0_rvalid,
   output logic             init_done
);

   if (WIDTH % MASK_GRAN != 0) begin : g_bad_gran
      $fatal(1, "sram_1p_masked_array: WIDTH must be a multiple of MASK_GRAN");
   end
   if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
      $fatal(1, "sram_1p_masked_array: READ_LAT must be 1 or 2");
   end

   typedef enum logic [0:0] {StInit, StReady} state_e;

   localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

   state_e           r_state;
   state_e           w_state_next;
   logic [AW-1:0]    r_cnt;
   logic [AW-1:0]    w_cnt_next;
   logic             w_init_we;
   logic             w_ready;
   logic             w_in_range;
   logic             w_wr;
   logic             w_rd;
   logic [WIDTH-1:0] w_bitmask;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             r_rd1_vld;
   logic [WIDTH-1:0] r_rd1_data;

   // ---------------------------------------------------------------- init FSM
   always_ff @(posedge RW0_clk or posedge reset) begin
      if (reset) begin
         r_state <= StInit;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StInit:  if (r_cnt == LastIdx) w_state_next = StReady;
         StReady: w_state_next = StReady;
         default: w_state_next = StInit;
      endcase
   end

   always_comb begin
      w_init_we  = 1'b0;
      w_ready    = 1'b0;
      w_cnt_next = r_cnt;
      case (r_state)
         StInit: begin
            // Gated with reset so a held reset never writes the array.
            w_init_we  = ~reset;
            w_cnt_next = r_cnt + 1'b1;
         end
         StReady: w_ready = 1'b1;
         default: ;
      endcase
   end

   // r_state is a single flop, so this is a registered output.
   assign init_done = w_ready;

   // ---------------------------------------------------------------- port decode
   if ((1 << AW) == DEPTH) begin : g_pow2
      assign w_in_range = 1'b1;
   end else begin : g_npow2
      localparam logic [AW:0] DepthExt = (AW + 1)'(DEPTH);
      assign w_in_range = ({1'b0, RW0_addr} < DepthExt);
   end

   assign w_wr = w_ready & RW0_en & RW0_wmode & w_in_range;
   assign w_rd = w_ready & RW0_en & ~RW0_wmode;

   always_comb begin
      w_bitmask = '0;
      for (int unsigned i = 0; i < MW; i++) begin
         w_bitmask[i*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{RW0_wmask[i]}};
      end
   end

   // ---------------------------------------------------------------- storage
   always_ff @(posedge RW0_clk) begin
      if (w_init_we) begin
         r_mem[r_cnt] <= '0;
      end else if (w_wr) begin
         r_mem[RW0_addr] <= (r_mem[RW0_addr] & ~w_bitmask) | (RW0_wdata & w_bitmask);
      end
   end

   // ---------------------------------------------------------------- read pipeline
   // Data registers only load on a valid result, which gives the hold behaviour.
   always_ff @(posedge RW0_clk or posedge reset) begin
      if (reset) begin
         r_rd1_vld  <= 1'b0;
         r_rd1_data <= '0;
      end else begin
         r_rd1_vld <= w_rd;
         if (w_rd) begin
            r_rd1_data <= w_in_range ? r_mem[RW0_addr] : '0;
         end
      end
   end

   if (READ_LAT == 2) begin : g_lat2
      logic             r_rd2_vld;
      logic [WIDTH-1:0] r_rd2_data;

      always_ff @(posedge RW0_clk or posedge reset) begin
         if (reset) begin
            r_rd2_vld  <= 1'b0;
            r_rd2_data <= '0;
         end else begin
            r_rd2_vld <= r_rd1_vld;
            if (r_rd1_vld) begin
               r_rd2_data <= r_rd1_data;
            end
         end
      end

      assign RW0_rdata  = r_rd2_data;
      assign RW0_rvalid = r_rd2_vld;
   end else begin : g_lat1
      assign RW0_rdata  = r_rd1_data;
      assign RW0_rvalid = r_rd1_vld;
   end

endmodule
